// File: rtl/red_pitaya_rail_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : red_pitaya_rail_monitor
//  Description : Watches the limit block's railed[1:0] flags. Short rail
//                excursions are filtered out. A run of hold_cycles_i
//                consecutive railed cycles declares lock loss, pulses an
//                integrator reset and latches the rail direction. The monitor
//                re-arms after release_cycles_i consecutive quiet cycles.
//  Ports       : clk_i, rst_i        - clock, synchronous active-high reset
//                enable_i            - low forces IDLE
//                railed_i[1:0]       - [0] at min rail, [1] at max rail
//                hold_cycles_i       - railed run length for loss (0 acts as 1)
//                release_cycles_i    - quiet run length to re-arm (0 acts as 1)
//                clear_i             - clears event counter and latched direction
//                state_o             - 0 IDLE, 1 ARMED, 2 PENDING, 3 LOST
//                lock_lost_o         - high while LOST
//                int_reset_o         - one-cycle pulse on LOST entry
//                rail_dir_o          - rail flags captured on LOST entry
//                event_cnt_o         - saturating count of LOST entries
//  Revision    : 1.0 - initial release
// ============================================================================
module red_pitaya_rail_monitor #(
    parameter int CNTW = 24,
    parameter int EVW  = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            enable_i,
    input  logic [1:0]      railed_i,
    input  logic [CNTW-1:0] hold_cycles_i,
    input  logic [CNTW-1:0] release_cycles_i,
    input  logic            clear_i,
    output logic [1:0]      state_o,
    output logic            lock_lost_o,
    output logic            int_reset_o,
    output logic [1:0]      rail_dir_o,
    output logic [EVW-1:0]  event_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_PENDING = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [1:0]      railed_q, railed_d;
    logic            int_reset_q, int_reset_d;
    logic [1:0]      rail_dir_q, rail_dir_d;
    logic [EVW-1:0]  event_cnt_q, event_cnt_d;

    logic            any_railed;
    logic            enter_lost;
    logic [CNTW-1:0] cnt_inc;
    logic [CNTW-1:0] hold_eff;
    logic [CNTW-1:0] release_eff;

    // Decisions are made on the registered flags, so both rails at once
    // still counts as railed and no input reaches an output combinationally.
    assign any_railed  = |railed_q;
    assign cnt_inc     = (cnt_q == {CNTW{1'b1}}) ? cnt_q : cnt_q + CNTW'(1);
    assign hold_eff    = (hold_cycles_i == '0) ? CNTW'(1) : hold_cycles_i;
    assign release_eff = (release_cycles_i == '0) ? CNTW'(1) : release_cycles_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        railed_d    = railed_i;
        int_reset_d = 1'b0;
        rail_dir_d  = rail_dir_q;
        event_cnt_d = event_cnt_q;
        enter_lost  = 1'b0;

        if (!enable_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (any_railed) begin
                        cnt_d = CNTW'(1);
                        if (hold_eff == CNTW'(1)) begin
                            enter_lost = 1'b1;
                        end else begin
                            state_d = ST_PENDING;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                ST_PENDING: begin
                    if (!any_railed) begin
                        // Excursion too short: back to ARMED, start over.
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        // Live compare so a lowered threshold acts at once.
                        if (cnt_inc >= hold_eff) begin
                            enter_lost = 1'b1;
                        end
                    end
                end
                ST_LOST: begin
                    // In LOST the counter tracks the quiet run length.
                    if (any_railed) begin
                        cnt_d = '0;
                    end else if (cnt_inc >= release_eff) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (enter_lost) begin
            state_d     = ST_LOST;
            cnt_d       = '0;
            int_reset_d = 1'b1;
            rail_dir_d  = railed_q;
            if (event_cnt_q != {EVW{1'b1}}) begin
                event_cnt_d = event_cnt_q + EVW'(1);
            end
        end

        // Clear has priority over a simultaneous LOST entry's bookkeeping.
        if (clear_i) begin
            event_cnt_d = '0;
            rail_dir_d  = 2'b00;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            railed_q    <= 2'b00;
            int_reset_q <= 1'b0;
            rail_dir_q  <= 2'b00;
            event_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            railed_q    <= railed_d;
            int_reset_q <= int_reset_d;
            rail_dir_q  <= rail_dir_d;
            event_cnt_q <= event_cnt_d;
        end
    end

    assign state_o     = state_q;
    assign lock_lost_o = (state_q == ST_LOST);
    assign int_reset_o = int_reset_q;
    assign rail_dir_o  = rail_dir_q;
    assign event_cnt_o = event_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_rail_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_red_pitaya_rail_monitor
//  Description : Directed self-checking bench for red_pitaya_rail_monitor.
//                Inputs change 1 ns after a rising edge; outputs are sampled
//                at the same point, away from the active edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_red_pitaya_rail_monitor;

    localparam int CNTW = 24;
    localparam int EVW  = 2;

    logic            clk;
    logic            rst;
    logic            enable;
    logic [1:0]      railed;
    logic [CNTW-1:0] hold_cycles;
    logic [CNTW-1:0] release_cycles;
    logic            clear;
    logic [1:0]      state;
    logic            lock_lost;
    logic            int_reset;
    logic [1:0]      rail_dir;
    logic [EVW-1:0]  event_cnt;

    int errors = 0;
    int checks = 0;

    red_pitaya_rail_monitor #(
        .CNTW(CNTW),
        .EVW (EVW)
    ) u_dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .enable_i        (enable),
        .railed_i        (railed),
        .hold_cycles_i   (hold_cycles),
        .release_cycles_i(release_cycles),
        .clear_i         (clear),
        .state_o         (state),
        .lock_lost_o     (lock_lost),
        .int_reset_o     (int_reset),
        .rail_dir_o      (rail_dir),
        .event_cnt_o     (event_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic ll,
                           input logic ir, input logic [1:0] dir, input logic [EVW-1:0] ev);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".lock_lost"}, 32'(lock_lost), 32'(ll));
        chk({tag, ".int_reset"}, 32'(int_reset), 32'(ir));
        chk({tag, ".rail_dir"}, 32'(rail_dir), 32'(dir));
        chk({tag, ".event_cnt"}, 32'(event_cnt), 32'(ev));
    endtask

    initial begin
        rst            = 1'b1;
        enable         = 1'b0;
        railed         = 2'b00;
        hold_cycles    = CNTW'(10);
        release_cycles = CNTW'(5);
        clear          = 1'b0;
        step(2);
        chk_all("reset", 2'd0, 1'b0, 1'b0, 2'b00, 2'd0);

        rst    = 1'b0;
        enable = 1'b1;
        step(1);
        chk("idle_to_armed", 32'(state), 32'd1);

        // 1: max rail held, H=10 -> LOST after edge t+10
        railed = 2'b10;
        step(1);                                   // edge t: first sample
        chk("t1_first_sample", 32'(state), 32'd1);
        step(9);                                   // edges t+1..t+9
        chk_all("t1_pending", 2'd2, 1'b0, 1'b0, 2'b00, 2'd0);
        step(1);                                   // edge t+10
        chk_all("t1_lost", 2'd3, 1'b1, 1'b1, 2'b10, 2'd1);
        step(1);
        chk_all("t1_pulse_end", 2'd3, 1'b1, 1'b0, 2'b10, 2'd1);
        step(8);
        chk_all("t1_held", 2'd3, 1'b1, 1'b0, 2'b10, 2'd1);

        // 3: R=5, quiet 4, railed 1, quiet 5 -> ARMED only after the 5th quiet
        railed = 2'b00;
        step(4);
        railed = 2'b10;
        step(1);
        chk("t3_quiet4", 32'(state), 32'd3);
        railed = 2'b00;
        step(5);
        chk("t3_not_yet", 32'(state), 32'd3);
        step(1);
        chk_all("t3_rearmed", 2'd1, 1'b0, 1'b0, 2'b10, 2'd1);

        // 2: high 9, low 1, high 9 -> glitch rejected, never LOST
        railed = 2'b01;
        step(9);
        railed = 2'b00;
        step(1);
        chk("t2_pending", 32'(state), 32'd2);
        railed = 2'b01;
        step(1);
        chk("t2_rejected", 32'(state), 32'd1);
        step(8);
        chk("t2_pending2", 32'(state), 32'd2);
        railed = 2'b00;
        step(2);
        chk_all("t2_armed", 2'd1, 1'b0, 1'b0, 2'b10, 2'd1);

        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk_all("clear", 2'd1, 1'b0, 1'b0, 2'b00, 2'd0);

        // 4: H=0,R=0 -> single railed cycle, direct ARMED->LOST, one quiet re-arms
        hold_cycles    = '0;
        release_cycles = '0;
        railed = 2'b01;
        step(1);
        railed = 2'b00;
        step(1);
        chk_all("t4_lost", 2'd3, 1'b1, 1'b1, 2'b01, 2'd1);
        step(1);
        chk_all("t4_rearm", 2'd1, 1'b0, 1'b0, 2'b01, 2'd1);

        // 5: EVW=2 saturates at 3
        for (int i = 0; i < 4; i++) begin
            railed = 2'b10;
            step(1);
            railed = 2'b00;
            step(1);
            chk("t5_ev_lost", 32'(state), 32'd3);
            chk("t5_ev_cnt", 32'(event_cnt), (i == 0) ? 32'd2 : 32'd3);
            step(1);
        end
        // clear on the LOST-entry cycle wins
        railed = 2'b10;
        step(1);
        railed = 2'b00;
        clear  = 1'b1;
        step(1);
        clear  = 1'b0;
        chk_all("t5_clear_entry", 2'd3, 1'b1, 1'b1, 2'b00, 2'd0);
        step(1);
        chk("t5_rearm", 32'(state), 32'd1);

        // 6: enable low mid-PENDING restarts the count; both rails count
        hold_cycles    = CNTW'(10);
        release_cycles = CNTW'(5);
        railed = 2'b11;
        step(4);
        chk("t6_pending", 32'(state), 32'd2);
        enable = 1'b0;
        step(1);
        chk_all("t6_idle", 2'd0, 1'b0, 1'b0, 2'b00, 2'd0);
        enable = 1'b1;
        step(1);
        chk("t6_armed", 32'(state), 32'd1);
        step(9);
        chk("t6_restart", 32'(state), 32'd2);
        step(1);
        chk_all("t6_lost11", 2'd3, 1'b1, 1'b1, 2'b11, 2'd1);
        enable = 1'b0;
        step(1);
        chk_all("t6_lost_disable", 2'd0, 1'b0, 1'b0, 2'b11, 2'd1);

        // reset mid-PENDING
        enable = 1'b1;
        step(3);
        chk("t6_pending_b", 32'(state), 32'd2);
        rst = 1'b1;
        step(1);
        chk_all("t6_reset", 2'd0, 1'b0, 1'b0, 2'b00, 2'd0);
        rst = 1'b0;

        // lowering H below the running count triggers on the next edge
        step(1);
        step(5);
        chk("lowH_pending", 32'(state), 32'd2);
        hold_cycles = CNTW'(3);
        step(1);
        chk_all("lowH_lost", 2'd3, 1'b1, 1'b1, 2'b11, 2'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
